// File: rtl/miter_stim_checker_pkg.sv
// rtl/miter_stim_checker_pkg.sv - shared types and constants for the miter stimulus checker
package miter_stim_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int Y_W        = 91;
    localparam int CNT_W      = 16;
    localparam int LFSR_W     = 68;
    localparam int LFSR_TAP_A = 68;
    localparam int LFSR_TAP_B = 59;

    localparam int W0_W = 14;
    localparam int W0_LSB = 0;
    localparam int W1_W = 11;
    localparam int W1_LSB = 14;
    localparam int W2_W = 12;
    localparam int W2_LSB = 25;
    localparam int W3_W = 20;
    localparam int W3_LSB = 37;
    localparam int W4_W = 11;
    localparam int W4_LSB = 57;

    // An all-zero Fibonacci LFSR never leaves zero, so substitute 1.
    function automatic logic [LFSR_W-1:0] lfsr_seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_A-1] ^ s[LFSR_TAP_B-1]};
    endfunction

endpackage

// File: rtl/miter_stim_checker_if.sv
// rtl/miter_stim_checker_if.sv - stimulus and response bundle between checker and compared designs
interface miter_stim_checker_if;
    import miter_stim_checker_pkg::*;

    logic        [W0_W-1:0] wire0;
    logic signed [W1_W-1:0] wire1;
    logic signed [W2_W-1:0] wire2;
    logic signed [W3_W-1:0] wire3;
    logic signed [W4_W-1:0] wire4;
    logic        [Y_W-1:0]  y_1;
    logic        [Y_W-1:0]  y_2;

    modport master (
        output wire0, wire1, wire2, wire3, wire4,
        input  y_1, y_2
    );

    modport slave (
        input  wire0, wire1, wire2, wire3, wire4,
        output y_1, y_2
    );

endinterface

// File: rtl/miter_lfsr68.sv
// rtl/miter_lfsr68.sv - 68-bit Fibonacci LFSR with load and advance controls
module miter_lfsr68
    import miter_stim_checker_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 68'h0_DEAD_BEEF_CAFE_F00D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] SEED_EFF = lfsr_seed_fix(SEED);

    logic [LFSR_W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED_EFF;
        end else if (advance) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED_EFF;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/miter_stim_checker.sv
// rtl/miter_stim_checker.sv - drives LFSR stimulus into two designs and compares their outputs
module miter_stim_checker
    import miter_stim_checker_pkg::*;
#(
    parameter int                NUM_VECTORS = 1024,
    parameter int                DUT_LAT     = 1,
    parameter logic [LFSR_W-1:0] SEED        = 68'h0_DEAD_BEEF_CAFE_F00D
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    miter_stim_checker_if.master mif,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     mismatch_cnt,
    output logic [CNT_W-1:0]     first_fail_idx,
    output logic [Y_W-1:0]       first_fail_diff
);

    localparam int DL_D    = (DUT_LAT == 0) ? 1 : DUT_LAT;
    localparam int DL_TAIL = (DUT_LAT == 0) ? 0 : DUT_LAT - 1;
    localparam logic [LFSR_W-1:0] SEED_EFF = lfsr_seed_fix(SEED);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [3:0]        drain_q, drain_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  ffi_q, ffi_d;
    logic [Y_W-1:0]    ffd_q, ffd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [LFSR_W-1:0] stim_q, stim_d;
    logic              dl_vld_q [DL_D];
    logic              dl_vld_d [DL_D];
    logic [CNT_W-1:0]  dl_idx_q [DL_D];
    logic [CNT_W-1:0]  dl_idx_d [DL_D];

    logic              accept;
    logic              last_vec;
    logic              cmp_vld;
    logic [CNT_W-1:0]  cmp_idx;
    logic              miss;
    logic [LFSR_W-1:0] lfsr_state;

    assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_vec = (idx_q == CNT_W'(NUM_VECTORS - 1));

    miter_lfsr68 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .advance (state_q == ST_RUN),
        .state   (lfsr_state)
    );

    // Valid/index tags follow each vector so its comparison lands DUT_LAT cycles later.
    always_comb begin
        dl_vld_d[0] = (state_q == ST_RUN);
        dl_idx_d[0] = idx_q;
        for (int i = 1; i < DL_D; i++) begin
            dl_vld_d[i] = dl_vld_q[i-1];
            dl_idx_d[i] = dl_idx_q[i-1];
        end
    end

    assign cmp_vld = (DUT_LAT == 0) ? (state_q == ST_RUN) : dl_vld_q[DL_TAIL];
    assign cmp_idx = (DUT_LAT == 0) ? idx_q : dl_idx_q[DL_TAIL];
    assign miss    = cmp_vld && (mif.y_1 != mif.y_2);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;
        ffi_d   = ffi_q;
        ffd_d   = ffd_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        stim_d  = stim_q;

        if (miss) begin
            if (cnt_q == '0) begin
                ffi_d = cmp_idx;
                ffd_d = mif.y_1 ^ mif.y_2;
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    ffi_d   = '0;
                    ffd_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    stim_d  = SEED_EFF;
                end
            end
            ST_RUN: begin
                if (!last_vec) begin
                    idx_d  = idx_q + 1'b1;
                    stim_d = lfsr_step(lfsr_state);
                end else if (DUT_LAT == 0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (cnt_d == '0);
                end else begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 4'(DUT_LAT - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (cnt_d == '0);
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            drain_q  <= '0;
            cnt_q    <= '0;
            ffi_q    <= '0;
            ffd_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            stim_q   <= '0;
            dl_vld_q <= '{default: 1'b0};
            dl_idx_q <= '{default: '0};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            drain_q  <= drain_d;
            cnt_q    <= cnt_d;
            ffi_q    <= ffi_d;
            ffd_q    <= ffd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            stim_q   <= stim_d;
            dl_vld_q <= dl_vld_d;
            dl_idx_q <= dl_idx_d;
        end
    end

    assign mif.wire0 = stim_q[W0_LSB +: W0_W];
    assign mif.wire1 = stim_q[W1_LSB +: W1_W];
    assign mif.wire2 = stim_q[W2_LSB +: W2_W];
    assign mif.wire3 = stim_q[W3_LSB +: W3_W];
    assign mif.wire4 = stim_q[W4_LSB +: W4_W];

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign mismatch_cnt    = cnt_q;
    assign first_fail_idx  = ffi_q;
    assign first_fail_diff = ffd_q;

endmodule
